// File: rtl/instr_fetch.sv
// instr_fetch: PC, single-outstanding imem fetch, IF/ID holding buffer with redirect flush.
// Define FETCH_SKID_EN to widen the holding buffer to a 2-entry FIFO.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct,
  output logic        misalign
);
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;
  state_t      state, state_nx;
  logic [31:0] pc, addr_q;
  logic        full, pop, push, accept, outstanding;
  ent_t        head, ent_in;
  assign pop            = id_valid & id_ready;
  assign accept         = imem_req_valid & imem_req_ready;
  assign push           = (state == WAIT) & imem_rsp_valid & !redirect_valid;
  assign ent_in         = '{instr: imem_rsp_data, pc: addr_q, pc4: addr_q + 32'd4};
  assign imem_req_valid = rst_n & (state == REQ) & (!full | pop);
  assign imem_req_addr  = {pc[31:2], 2'b00};
  // a response landing in the redirect cycle retires the outstanding request
  assign outstanding    = (state != REQ) & !imem_rsp_valid;
  assign id_instr       = head.instr;
  assign id_pc          = head.pc;
  assign id_pc4         = head.pc4;
  assign id_opcode      = head.instr[31:26];
  assign id_funct       = head.instr[5:0];
  always_comb begin
    state_nx = state;
    if (redirect_valid)
      state_nx = (outstanding | accept) ? DROP : REQ;
    else if (state == REQ)
      state_nx = accept ? WAIT : REQ;
    else
      state_nx = imem_rsp_valid ? REQ : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      pc       <= RESET_PC;
      addr_q   <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nx;
      misalign <= redirect_valid & |redirect_pc[1:0];
      if (redirect_valid)
        pc <= {redirect_pc[31:2], 2'b00};
      else if (accept)
        pc <= pc + 32'd4;
      if (accept)
        addr_q <= imem_req_addr;
    end
  end
`ifdef FETCH_SKID_EN
  logic [1:0] cnt;
  ent_t       e0, e1;
  assign full     = cnt == 2'd2;
  assign id_valid = cnt != 2'd0;
  assign head     = e0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      cnt <= redirect_valid ? 2'd0 : cnt + 2'(push) - 2'(pop);
      if (pop)
        e0 <= e1;
      if (push) begin
        if (cnt == 2'd0 || (cnt == 2'd1 && pop))
          e0 <= ent_in;
        else
          e1 <= ent_in;
      end
    end
  end
`else
  logic vld;
  ent_t e0;
  assign full     = vld;
  assign id_valid = vld;
  assign head     = e0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      e0  <= '0;
    end else begin
      vld <= !redirect_valid & (push | (vld & !pop));
      if (push)
        e0 <= ent_in;
    end
  end
`endif
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that feeds the control decoder. It holds the program counter and issues single-outstanding reads to instruction memory over a valid/ready handshake. It buffers returned words in an IF/ID holding register and presents them, with the opcode and funct fields pre-split, to the decode stage and `Ctrl`. Taken branches from execute redirect it, which flushes any younger fetched or in-flight instruction.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: first fetch address after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: word-aligned fetch address; bits [1:0] are always 0.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: read data valid; at most one response per accepted request, in order.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: branch taken (from `ctrlBranch` and the ALU result in EX).
- `redirect_pc` in 32: branch target.
- `id_ready` in 1: decode stage accepts the head entry.
- `id_valid` out 1: head entry valid.
- `id_instr` out 32: instruction word.
- `id_pc` out 32: instruction address.
- `id_pc4` out 32: `id_pc` + 4, used by the branch adder.
- `id_opcode` out 6: `id_instr[31:26]`.
- `id_funct` out 6: `id_instr[5:0]`.
- `misalign` out 1: one-cycle pulse when `redirect_pc[1:0]` is non-zero.

## Operation
- State machine has three states: REQ, WAIT and DROP. Reset state is REQ.
- REQ:
  - `imem_req_valid` = 1 when a buffer slot will be free, i.e. the buffer is not full, or the head is popping this cycle.
  - On accept (`imem_req_valid & imem_req_ready`): `pc <= pc + 4`, store the address, go to WAIT.
- WAIT:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: push {data, stored address} into the buffer and go to REQ.
- DROP:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: discard the data and go to REQ.
- Redirect has top priority over all other events:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - The buffer is flushed, so `id_valid` = 0 next cycle.
  - If a request was outstanding or is accepted this cycle, go to DROP; otherwise go to REQ.
  - A `id_valid & id_ready` transfer in the same cycle is void. Decode qualifies its capture with `!redirect_valid`.
- If `imem_rsp_valid` and `redirect_valid` arrive in the same WAIT cycle, the response is discarded and the FSM goes to REQ, not DROP.
- Pop occurs when `id_valid & id_ready`.
- The buffer is one entry by default; its capacity is 2 with `FETCH_SKID_EN`.
- Push to a full buffer cannot occur, because the issue rule above prevents it.
- `pc + 4` wraps modulo 2^32; no fault is raised.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, state = REQ, buffer empty.
  - `id_valid` = 0, `misalign` = 0, `imem_req_valid` = 0 while `rst_n` = 0.
  - `id_instr`, `id_pc`, `id_pc4`, `id_opcode` and `id_funct` are 0 while `rst_n` = 0.
- First request: `imem_req_valid` = 1 in the first cycle after `rst_n` deasserts, with addr = `RESET_PC`.
- Latency, with a one-cycle memory: request accept at cycle N, response at N+1, `id_valid` at N+2. The next request is issued at N+2.
- Steady throughput is 1 instruction per 2 cycles.
- Redirect at cycle N: earliest request to the target at N+1 (from REQ). Earliest `id_valid` for the target is at N+3.
- `misalign` is registered and asserts the cycle after the redirect.
- Data outputs are stable while `id_valid & !id_ready`.

## Configuration
- `FETCH_SKID_EN` defined: the buffer is a 2-entry FIFO.
  - While decode stalls with one entry held, one more fetch proceeds.
  - When the stall releases, entries issue back-to-back.
- `FETCH_SKID_EN` undefined: single holding register.
  - No request is issued while the head is held and not popping.

## Test plan
- Reset release with `RESET_PC` = 32'h3000 and a one-cycle memory returning 32'h20080005: request at 32'h3000.
  - Two cycles after accept: `id_valid` = 1, `id_opcode` = 6'h08, `id_pc4` = 32'h3004.
- Continuous `id_ready` = 1 over 4 instructions: `id_pc` sequence 3000, 3004, 3008, 300C, one instruction every 2 cycles.
- Hold `id_ready` = 0 for 5 cycles with the head valid:
  - Outputs are stable throughout.
  - Without the macro: exactly 1 accepted request. With `FETCH_SKID_EN`: 2 accepted requests, then 2 consecutive pops after release.
- Redirect to 32'h3040 while in WAIT (memory latency 3):
  - The stale response is dropped and `id_valid` stays 0.
  - Next request address is 32'h3040 and the next `id_pc` is 32'h3040.
- Redirect to 32'h3042: `misalign` pulses for 1 cycle and the fetch address is 32'h3040.
- Assert `rst_n` low mid-WAIT with a response pending: outputs reset immediately. After release, the first request is at `RESET_PC` and no stale data appears.
